// File: rtl/current_direction_fsm.sv
// current_direction_fsm
//   Classifies IEEE 754 single-precision battery current samples as
//   positive (charging), negative (discharging), zero (idle) or bad
//   (Inf/NaN), debounces the class, and tracks the resulting direction
//   state with a saturating dwell counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   qualifies in_data for one cycle
//   in_data    float32 current sample
//   fault_clr  request to leave FAULT (ignored elsewhere)
//   state      IDLE=00, CHARGING=01, DISCHARGING=10, FAULT=11
//   state_chg  one-cycle pulse after every state change
//   dwell      accepted samples since the current state was entered
//   gt/lt/eq   registered class of the last accepted sample
module current_direction_fsm #(
  parameter int DEBOUNCE = 4,
  parameter int DWELL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic               fault_clr,
  output logic [1:0]         state,
  output logic               state_chg,
  output logic [DWELL_W-1:0] dwell,
  output logic               gt,
  output logic               lt,
  output logic               eq
);

  localparam logic [1:0] IDLE        = 2'b00;
  localparam logic [1:0] CHARGING    = 2'b01;
  localparam logic [1:0] DISCHARGING = 2'b10;
  localparam logic [1:0] FAULT       = 2'b11;

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_POS  = 2'd1;
  localparam logic [1:0] CLS_NEG  = 2'd2;
  localparam logic [1:0] CLS_BAD  = 2'd3;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [1:0] cand;
  logic [3:0] run;

  logic [1:0] cls;
  logic [1:0] tgt;
  logic [3:0] run_nxt;

  // Denormals are folded into ZERO: they are far below any meaningful
  // current and must not trip a direction change.
  function automatic logic [1:0] classify(input logic [31:0] d);
    logic [1:0] c;
    if (d[30:23] == 8'hFF)      c = CLS_BAD;
    else if (d[30:23] == 8'h00) c = CLS_ZERO;
    else if (d[31])             c = CLS_NEG;
    else                        c = CLS_POS;
    return c;
  endfunction

  function automatic logic [3:0] run_sat_inc(input logic [3:0] r);
    return (r >= DEB) ? DEB : r + 4'd1;
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_sat_inc(input logic [DWELL_W-1:0] d);
    return (&d) ? d : d + DWELL_W'(1);
  endfunction

  always_comb begin
    cls = classify(in_data);
    case (cls)
      CLS_POS: tgt = CHARGING;
      CLS_NEG: tgt = DISCHARGING;
      CLS_BAD: tgt = FAULT;
      default: tgt = IDLE;
    endcase
    run_nxt = (cls == cand) ? run_sat_inc(run) : 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      state_chg <= 1'b0;
      dwell     <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      cand      <= CLS_ZERO;
      run       <= 4'd0;
    end else begin
      state_chg <= 1'b0;
      if (in_valid) begin
        gt <= (cls == CLS_POS);
        lt <= (cls == CLS_NEG);
        eq <= (cls == CLS_ZERO);
        if (cls == CLS_BAD) begin
          // BAD bypasses debounce and beats a simultaneous fault_clr.
          state     <= FAULT;
          state_chg <= (state != FAULT);
          dwell     <= (state != FAULT) ? '0 : dwell_sat_inc(dwell);
          cand      <= CLS_BAD;
          run       <= 4'd0;
        end else if (state == FAULT) begin
          if (fault_clr) begin
            state     <= IDLE;
            state_chg <= 1'b1;
            dwell     <= '0;
            cand      <= CLS_ZERO;
            run       <= 4'd0;
          end else begin
            cand  <= cls;
            run   <= run_nxt;
            dwell <= dwell_sat_inc(dwell);
          end
        end else begin
          cand <= cls;
          run  <= run_nxt;
          if (run_nxt == DEB && tgt != state) begin
            state     <= tgt;
            state_chg <= 1'b1;
            dwell     <= '0;
          end else begin
            dwell <= dwell_sat_inc(dwell);
          end
        end
      end else if (state == FAULT && fault_clr) begin
        state     <= IDLE;
        state_chg <= 1'b1;
        dwell     <= '0;
        cand      <= CLS_ZERO;
        run       <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_current_direction_fsm.sv
// Bench for current_direction_fsm: a default instance (DEBOUNCE=4,
// DWELL_W=16) and a DEBOUNCE=1, DWELL_W=2 instance for the immediate
// switching and dwell saturation cases.
module tb_current_direction_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, fault_clr;
  logic [31:0] in_data;
  logic [1:0]  state;
  logic        state_chg, gt, lt, eq;
  logic [15:0] dwell;

  logic        in_valid1, fault_clr1;
  logic [31:0] in_data1;
  logic [1:0]  state1;
  logic        state_chg1, gt1, lt1, eq1;
  logic [1:0]  dwell1;

  int tests = 0;
  int fails = 0;

  logic [21:0] sb[$];
  logic [7:0]  sb1[$];
  logic [21:0] got, exp;
  logic [7:0]  got1, exp1;

  localparam logic [31:0] P4   = 32'h40800000;
  localparam logic [31:0] N4   = 32'hC0800000;
  localparam logic [31:0] NZ   = 32'h80000000;
  localparam logic [31:0] PZ   = 32'h00000000;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  always #5 clk = ~clk;

  current_direction_fsm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .fault_clr(fault_clr), .state(state), .state_chg(state_chg),
    .dwell(dwell), .gt(gt), .lt(lt), .eq(eq)
  );

  current_direction_fsm #(.DEBOUNCE(1), .DWELL_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .fault_clr(fault_clr1), .state(state1), .state_chg(state_chg1),
    .dwell(dwell1), .gt(gt1), .lt(lt1), .eq(eq1)
  );

  function automatic logic [21:0] mk(input logic [1:0] st, input logic chg,
                                     input logic [2:0] gle, input logic [15:0] dw);
    return {st, chg, gle, dw};
  endfunction

  function automatic logic [7:0] mk1(input logic [1:0] st, input logic chg,
                                     input logic [2:0] gle, input logic [1:0] dw);
    return {st, chg, gle, dw};
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic fc);
    @(negedge clk);
    in_valid = v; in_data = d; fault_clr = fc;
    @(posedge clk);
    #1;
    in_valid = 1'b0; fault_clr = 1'b0;
    got = {state, state_chg, gt, lt, eq, dwell};
  endtask

  task automatic step1(input logic [31:0] d);
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = d;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    got1 = {state1, state_chg1, gt1, lt1, eq1, dwell1};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    got = {state, state_chg, gt, lt, eq, dwell};
    if (got !== 22'd0) begin
      fails++; $display("FAIL reset_main got %h exp %h", got, 22'd0);
    end
    tests++;
    got1 = {state1, state_chg1, gt1, lt1, eq1, dwell1};
    if (got1 !== 8'd0) begin
      fails++; $display("FAIL reset_d1 got %h exp %h", got1, 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Four +4.0 samples from IDLE: switch on the 4th only, then state_chg drops.
  task automatic test_charge(input string tag);
    for (int i = 0; i < 4; i++) begin
      sb.push_back((i == 3) ? mk(2'b01, 1'b1, 3'b100, 16'd0)
                            : mk(2'b00, 1'b0, 3'b100, 16'(i + 1)));
      step(1'b1, P4, 1'b0);
      exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL %s[%0d] got %h exp %h", tag, i, got, exp);
      end
    end
    sb.push_back(mk(2'b01, 1'b0, 3'b100, 16'd0));
    step(1'b0, PZ, 1'b0);
    exp = sb.pop_front(); tests++;
    if (got !== exp) begin
      fails++; $display("FAIL %s_hold got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic test_zero_from_charging();
    for (int i = 0; i < 4; i++) begin
      sb.push_back((i == 3) ? mk(2'b00, 1'b1, 3'b001, 16'd0)
                            : mk(2'b01, 1'b0, 3'b001, 16'(i + 1)));
      step(1'b1, NZ, 1'b0);
      exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL neg_zero[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  // A single zero in a run of positives restarts the debounce.
  task automatic test_glitch();
    logic [31:0] seq [8];
    seq = '{P4, P4, P4, PZ, P4, P4, P4, P4};
    for (int i = 0; i < 8; i++) begin
      if (i == 7)      sb.push_back(mk(2'b01, 1'b1, 3'b100, 16'd0));
      else if (i == 3) sb.push_back(mk(2'b00, 1'b0, 3'b001, 16'(i + 1)));
      else             sb.push_back(mk(2'b00, 1'b0, 3'b100, 16'(i + 1)));
      step(1'b1, seq[i], 1'b0);
      exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL glitch[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_fault();
    logic        v [6];
    logic [31:0] d [6];
    logic        fc[6];
    v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    d  = '{QNAN, P4,   QNAN, PZ,   PZ,   PZ};
    fc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    sb.push_back(mk(2'b11, 1'b1, 3'b000, 16'd0)); // NaN from CHARGING
    sb.push_back(mk(2'b11, 1'b0, 3'b100, 16'd1)); // valid sample held in FAULT
    sb.push_back(mk(2'b11, 1'b0, 3'b000, 16'd2)); // BAD beats fault_clr
    sb.push_back(mk(2'b00, 1'b1, 3'b000, 16'd0)); // fault_clr -> IDLE
    sb.push_back(mk(2'b00, 1'b0, 3'b000, 16'd0)); // pulse ends
    sb.push_back(mk(2'b00, 1'b0, 3'b000, 16'd0)); // fault_clr ignored in IDLE
    for (int i = 0; i < 6; i++) begin
      step(v[i], d[i], fc[i]);
      exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL fault[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_dischg();
    for (int i = 0; i < 4; i++) begin
      sb.push_back((i == 3) ? mk(2'b10, 1'b1, 3'b010, 16'd0)
                            : mk(2'b01, 1'b0, 3'b010, 16'(i + 1)));
      step(1'b1, N4, 1'b0);
      exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL dischg[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(2'b10, 1'b0, 3'b100, 16'(i + 1)));
      step(1'b1, P4, 1'b0);
      exp = sb.pop_front(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL mid_pre[%0d] got %h exp %h", i, got, exp);
      end
    end
    @(negedge clk);
    #1 rst = 1'b1;
    sb.push_back(22'd0);
    #1;
    got = {state, state_chg, gt, lt, eq, dwell};
    exp = sb.pop_front(); tests++;
    if (got !== exp) begin
      fails++; $display("FAIL mid_async got %h exp %h", got, exp);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_debounce1();
    logic [31:0] d [8];
    d = '{32'h00000001, 32'h3F800000, 32'h3F800000, 32'h3F800000,
          32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hFF800000};
    sb1.push_back(mk1(2'b00, 1'b0, 3'b001, 2'd1)); // denormal is ZERO
    sb1.push_back(mk1(2'b01, 1'b1, 3'b100, 2'd0));
    sb1.push_back(mk1(2'b01, 1'b0, 3'b100, 2'd1));
    sb1.push_back(mk1(2'b01, 1'b0, 3'b100, 2'd2));
    sb1.push_back(mk1(2'b01, 1'b0, 3'b100, 2'd3));
    sb1.push_back(mk1(2'b01, 1'b0, 3'b100, 2'd3)); // dwell saturates
    sb1.push_back(mk1(2'b10, 1'b1, 3'b010, 2'd0));
    sb1.push_back(mk1(2'b11, 1'b1, 3'b000, 2'd0)); // -Inf
    for (int i = 0; i < 8; i++) begin
      step1(d[i]);
      exp1 = sb1.pop_front(); tests++;
      if (got1 !== exp1) begin
        fails++; $display("FAIL deb1[%0d] got %h exp %h", i, got1, exp1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; fault_clr = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; fault_clr1 = 1'b0;
    test_reset();
    test_charge("charge_a");
    test_zero_from_charging();
    test_glitch();
    test_fault();
    test_charge("charge_b");
    test_dischg();
    test_reset_mid();
    test_charge("charge_after_rst");
    test_debounce1();
    tests++;
    if (sb.size() != 0 || sb1.size() != 0) begin
      fails++; $display("FAIL scoreboard_left got %0d/%0d exp 0/0", sb.size(), sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
